// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and flag indices for the sequential ALU.
// Optional overflow flag is enabled by defining ALU_SEQ_OVF_EN.
package alu_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_AND = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_XOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
`ifdef ALU_SEQ_OVF_EN
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned NFLAGS = 4;
`else
  localparam int unsigned NFLAGS = 3;
`endif

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the ALU and its producer/consumer.
// flag_v exists only when ALU_SEQ_OVF_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             busy;
`ifdef ALU_SEQ_OVF_EN
  logic             flag_v;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, busy
`ifdef ALU_SEQ_OVF_EN
    , input flag_v
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, busy
`ifdef ALU_SEQ_OVF_EN
    , output flag_v
`endif
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: first partial product is taken on start,
// the remaining WIDTH-1 on following cycles; done pulses once the product is final.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             running;

  // Iteration 0 happens on the start edge so the total latency is exactly WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= b[0] ? PW'(a) : '0;
        mcand   <= PW'(a) << 1;
        mplier  <= b >> 1;
        cnt     <= CW'(1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; MUL uses the iterative multiplier.
// Define ALU_SEQ_OVF_EN to add the signed-overflow flag (flag_v).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned XW = WIDTH + 1;

  state_t state;
  state_t state_nxt;

  logic in_ready_q;
  logic in_ready_nxt;
  logic busy_q;
  logic busy_nxt;
  logic out_valid_q;
  logic out_valid_nxt;

  logic accept_c;
  logic is_mul_c;
  logic load_alu_c;
  logic load_mul_c;

  logic          mul_done;
  logic [PW-1:0] mul_product;

  logic [XW-1:0]     sum_c;
  logic [XW-1:0]     diff_c;
  logic [WIDTH-1:0]  alu_res_c;
  logic              alu_carry_c;
`ifdef ALU_SEQ_OVF_EN
  logic              alu_ovf_c;
`endif

  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  res_nxt;
  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_nxt;

  assign accept_c   = bus.in_valid && in_ready_q;
  assign is_mul_c   = (bus.op == OPW'(OP_MUL));
  assign load_alu_c = accept_c && !is_mul_c;
  assign load_mul_c = (state == ST_EXEC) && mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_c && is_mul_c),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept_c)      state_nxt = is_mul_c ? ST_EXEC : ST_DONE;
      ST_EXEC: if (mul_done)      state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    out_valid_nxt = 1'b0;
    unique case (state_nxt)
      ST_IDLE: in_ready_nxt  = 1'b1;
      ST_EXEC: busy_nxt      = 1'b1;
      ST_DONE: out_valid_nxt = 1'b1;
      default: in_ready_nxt  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_nxt;
      busy_q      <= busy_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  // Single-cycle operations; reserved opcodes fall through to zero.
  always_comb begin
    sum_c       = XW'(bus.a) + XW'(bus.b);
    diff_c      = XW'(bus.a) - XW'(bus.b);
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    case (bus.op)
      OPW'(OP_ADD): begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
      end
      OPW'(OP_SUB): begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];
      end
      OPW'(OP_AND): alu_res_c = bus.a & bus.b;
      OPW'(OP_OR):  alu_res_c = bus.a | bus.b;
      OPW'(OP_XOR): alu_res_c = bus.a ^ bus.b;
      default:      alu_res_c = '0;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  always_comb begin
    alu_ovf_c = 1'b0;
    if (bus.op == OPW'(OP_ADD)) begin
      alu_ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
    end else if (bus.op == OPW'(OP_SUB)) begin
      alu_ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_c[WIDTH-1] != bus.a[WIDTH-1]);
    end
  end
`endif

  // Result/flag capture; Z and N follow the value being loaded.
  always_comb begin
    res_nxt   = result_q;
    flags_nxt = flags_q;
    if (load_alu_c) begin
      res_nxt           = alu_res_c;
      flags_nxt[FLAG_C] = alu_carry_c;
`ifdef ALU_SEQ_OVF_EN
      flags_nxt[FLAG_V] = alu_ovf_c;
`endif
      flags_nxt[FLAG_Z] = (alu_res_c == '0);
      flags_nxt[FLAG_N] = alu_res_c[WIDTH-1];
    end else if (load_mul_c) begin
      res_nxt           = mul_product[WIDTH-1:0];
      flags_nxt[FLAG_C] = |mul_product[PW-1:WIDTH];
`ifdef ALU_SEQ_OVF_EN
      flags_nxt[FLAG_V] = 1'b0;
`endif
      flags_nxt[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
      flags_nxt[FLAG_N] = mul_product[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= res_nxt;
      flags_q  <= flags_nxt;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_c    = flags_q[FLAG_C];
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_n    = flags_q[FLAG_N];
`ifdef ALU_SEQ_OVF_EN
  assign bus.flag_v    = flags_q[FLAG_V];
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an arithmetic model.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(32), .OPW(3)) bus ();

  alu_seq #(.WIDTH(32), .OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic from the opcode rules, using 64-bit integers.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic v);
    longint unsigned ux, uy, p;
    logic signed [31:0] xs, ys;
    longint sx, sy, s;
    ux = 64'(x);
    uy = 64'(y);
    xs = x;
    ys = y;
    sx = xs;
    sy = ys;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: begin
        p = ux + uy; r = p[31:0]; c = (p > 64'h0000_0000_FFFF_FFFF);
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y; c = (x < y);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: begin
        p = ux * uy; r = p[31:0]; c = ((p >> 32) != 0);
      end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      default: r = '0;
    endcase
  endfunction

  // Issue one op at a negedge, check latency, result, flags, hold and release.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int stall);
    logic [31:0] er;
    logic ec, ev;
    int lat, bcnt, waited;
    model(o, x, y, er, ec, ev);
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end while (!bus.out_valid && lat < 200);
    check("latency", 64'(lat), (o == 3'd2) ? 64'(33) : 64'(1));
    check("busy_cycles", 64'(bcnt), (o == 3'd2) ? 64'(32) : 64'(0));
    check("result", 64'(bus.result), 64'(er));
    check("flag_c", 64'(bus.flag_c), 64'(ec));
    check("flag_z", 64'(bus.flag_z), 64'(er == 32'd0));
    check("flag_n", 64'(bus.flag_n), 64'(er[31]));
`ifdef ALU_SEQ_OVF_EN
    check("flag_v", 64'(bus.flag_v), 64'(ev));
`endif
    repeat (stall) @(negedge clk);
    check("hold_result", 64'(bus.result), 64'(er));
    check("hold_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("release_valid", 64'(bus.out_valid), 64'(0));
    check("release_ready", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          vcnt;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_flags", 64'({bus.flag_c, bus.flag_z, bus.flag_n, bus.busy}), 64'(0));

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    run_op(3'd1, 32'd5, 32'd7, 0);
    run_op(3'd1, 32'd7, 32'd7, 2);
    run_op(3'd1, 32'h8000_0000, 32'd1, 0);
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(3'd2, 32'h0000_1234, 32'h0000_0010, 1);
    run_op(3'd2, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'hF0F0_AAAA, 32'h0FF0_FFFF, 0);
    run_op(3'd4, 32'h1200_0000, 32'h0000_0034, 0);
    run_op(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    // Backpressure: a second offer during DONE must wait for the handoff.
    run_op(3'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 0);
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    bus.a = 32'hF0F0_F0F0;
    bus.b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.op = 3'd0;
    bus.a = 32'd1;
    bus.b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 64'(bus.result), 64'(32'h0F0F_0F0F));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", 64'(bus.in_ready), 64'(1));
    check("bp_idle_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", 64'(bus.out_valid), 64'(1));
    check("bp_second_result", 64'(bus.result), 64'(2));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'h0000_FFFF;
    bus.b = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) vcnt++;
    end
    check("mid_no_valid", 64'(vcnt), 64'(0));
    check("mid_result", 64'(bus.result), 64'(0));
    check("mid_flags", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'(0));
    check("mid_in_ready", 64'(bus.in_ready), 64'(1));
    run_op(3'd0, 32'd2, 32'd3, 0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        ra = ra & 32'h0000_FFFF;
        rb = rb & 32'h0000_FFFF;
      end
      if ($urandom_range(0, 5) == 0) rb = ra;
      run_op(ro, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
